// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and byte-lane merge helper for the data-memory responder.
package dmem_pkg;
   localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hBFD0;
   localparam logic [15:0] MMIO_LED         = 16'h0000;
   localparam logic [15:0] MMIO_SW          = 16'h0004;
   localparam logic [15:0] MMIO_TIMER       = 16'h0008;
   localparam logic [15:0] MMIO_CMP         = 16'h000C;
   localparam logic [31:0] CMP_RST          = 32'hFFFF_FFFF;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
      for (int i = 0; i < 4; i++)
         lane_merge[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
   endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM with byte-lane writes and a registered read port.
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int AW = 13
) (
   input  logic          i_clk,
   input  logic          i_en,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_din,
   output logic [31:0]   o_q
);
   logic [31:0] r_mem [2**AW];
   logic [31:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (|i_we) r_mem[i_addr] <= lane_merge(r_mem[i_addr], i_din, i_we);
         else r_q <= r_mem[i_addr];
      end
   end

   assign o_q = r_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder with RAM, LED/SW/TIMER/COMPARE MMIO page and 1-cycle read data.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          RAM_AW       = 13,
   parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst_n,
   input  logic [31:0] daddr,
   input  logic        dce,
   input  logic [3:0]  we,
   input  logic [31:0] din,
   output logic [31:0] dm,
   input  logic [15:0] sw,
   output logic [15:0] led,
   output logic        timer_irq
);
   logic        w_mmio, w_rd, w_mmio_wr, w_ram_en;
   logic [15:0] w_off;
   logic [31:0] w_mmio_rdata, w_ram_q, w_led_next;
   logic [15:0] r_led, r_sw_s1, r_sw_s2;
   logic [31:0] r_timer, r_cmp, r_mmio_q;
   logic        r_irq, r_sel_ram;

   assign w_mmio    = daddr[31:16] == MMIO_BASE_HI;
   assign w_off     = daddr[15:0];
   assign w_rd      = dce & ~|we;
   assign w_mmio_wr = dce & |we & w_mmio;
   // reset must suppress RAM writes in the same cycle
   assign w_ram_en  = cpu_rst_n & dce & ~w_mmio;

   dmem_ram #(.AW(RAM_AW)) u_ram (
      .i_clk  (cpu_clk_50M),
      .i_en   (w_ram_en),
      .i_we   (we),
      .i_addr (daddr[RAM_AW+1:2]),
      .i_din  (din),
      .o_q    (w_ram_q)
   );

   always_comb begin
      w_mmio_rdata = w_off == MMIO_LED   ? {16'h0, r_led}   :
                     w_off == MMIO_SW    ? {16'h0, r_sw_s2} :
                     w_off == MMIO_TIMER ? r_timer          :
                     w_off == MMIO_CMP   ? r_cmp            : 32'h0;
      w_led_next   = lane_merge({16'h0, r_led}, din, {2'b00, we[1:0]});
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (!cpu_rst_n) begin
         r_led     <= '0;
         r_sw_s1   <= '0;
         r_sw_s2   <= '0;
         r_timer   <= '0;
         r_cmp     <= CMP_RST;
         r_irq     <= 1'b0;
         r_sel_ram <= 1'b0;
         r_mmio_q  <= '0;
      end else begin
         r_sw_s1 <= sw;
         r_sw_s2 <= r_sw_s1;
         r_timer <= (w_mmio_wr && w_off == MMIO_TIMER) ? lane_merge(r_timer, din, we) : r_timer + 32'd1;
         if (w_mmio_wr && w_off == MMIO_LED) r_led <= w_led_next[15:0];
         if (w_mmio_wr && w_off == MMIO_CMP) r_cmp <= lane_merge(r_cmp, din, we);
         // a COMPARE write clears the flag even when it coincides with a match
         r_irq <= (w_mmio_wr && w_off == MMIO_CMP) ? 1'b0 : (r_irq | (r_timer == r_cmp));
         if (w_rd) begin
            r_sel_ram <= ~w_mmio;
            if (w_mmio) r_mmio_q <= w_mmio_rdata;
         end
      end
   end

   assign dm        = r_sel_ram ? w_ram_q : r_mmio_q;
   assign led       = r_led;
   assign timer_irq = r_irq;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_dmem_responder;
   logic        clk, rst_n, dce, timer_irq;
   logic [3:0]  we;
   logic [31:0] daddr, din, dm;
   logic [15:0] sw, led;

   localparam logic [31:0] A_LED = 32'hBFD0_0000, A_SW = 32'hBFD0_0004,
                           A_TMR = 32'hBFD0_0008, A_CMP = 32'hBFD0_000C;

   typedef struct {
      int          due;
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] act;
   int          cyc = 0, n_chk = 0, n_fail = 0;

   dmem_responder dut (
      .cpu_clk_50M (clk),
      .cpu_rst_n   (rst_n),
      .daddr       (daddr),
      .dce         (dce),
      .we          (we),
      .din         (din),
      .dm          (dm),
      .sw          (sw),
      .led         (led),
      .timer_irq   (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // kind 0 = dm, 1 = led, 2 = timer_irq; entries are checked in the cycle they fall due
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e   = sb.pop_front();
         act = e.kind == 0 ? dm : e.kind == 1 ? {16'h0, led} : {31'h0, timer_irq};
         n_chk++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
         end
      end
   end

   task automatic op(input logic d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] v);
      dce = d; we = w; daddr = a; din = v;
      @(posedge clk);
      #1;
      dce = 1'b0; we = 4'h0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] w);
      op(1'b1, w, a, v);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] x, input string nm);
      sb.push_back('{cyc + 1, 0, x, nm});
      op(1'b1, 4'h0, a, 32'h0);
   endtask

   task automatic chk(input int k, input logic [31:0] x, input string nm);
      sb.push_back('{cyc, k, x, nm});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; sw = '0; dce = 1'b0; we = '0; daddr = '0; din = '0;
      #1;
      idle(2);
      chk(0, 32'h0, "rst_dm"); chk(1, 32'h0, "rst_led"); chk(2, 32'h0, "rst_irq");
      rst_n = 1'b1;
      idle(1);
      wr(32'h100, 32'h1234_5678, 4'hF);
      chk(0, 32'h0, "dm_hold_on_write");
      rd(32'h100, 32'h1234_5678, "ram_word");
      wr(32'h104, 32'hAABB_CCDD, 4'hF);
      wr(32'h104, 32'h1122_3344, 4'b0101);
      chk(0, 32'h1234_5678, "dm_hold_on_writes");
      rd(32'h104, 32'hAA22_CC44, "byte_lanes");
      rd(32'h0000_8100, 32'h1234_5678, "ram_alias");
      wr(32'h200, 32'hDEAD_BEEF, 4'hF);
      rd(32'h200, 32'hDEAD_BEEF, "store_then_load");
      idle(1);
      chk(0, 32'hDEAD_BEEF, "dm_hold_idle");
      wr(A_LED, 32'h0000_A5A5, 4'hF);
      chk(1, 32'hA5A5, "led_write");
      wr(A_LED, 32'hFFFF_0000, 4'b1100);
      chk(1, 32'hA5A5, "led_upper_lanes_ignored");
      rd(A_LED, 32'h0000_A5A5, "led_read");
      sw = 16'h00F0;
      idle(3);
      rd(A_SW, 32'h0000_00F0, "sw_read");
      wr(A_SW, 32'h0000_FFFF, 4'hF);
      rd(A_SW, 32'h0000_00F0, "sw_write_ignored");
      rd(32'hBFD0_0010, 32'h0, "mmio_unmapped");
      wr(A_CMP, 32'h0000_0001, 4'hF);
      wr(A_TMR, 32'hFFFF_FFFE, 4'hF);
      rd(A_TMR, 32'hFFFF_FFFE, "timer_written");
      rd(A_TMR, 32'hFFFF_FFFF, "timer_max");
      rd(A_TMR, 32'h0000_0000, "timer_wrap");
      chk(2, 32'h0, "irq_before_match");
      rd(A_TMR, 32'h0000_0001, "timer_one");
      chk(2, 32'h1, "irq_on_match");
      idle(2);
      chk(2, 32'h1, "irq_sticky");
      wr(A_CMP, 32'h0000_0050, 4'hF);
      chk(2, 32'h0, "irq_cleared_by_cmp");
      rd(A_CMP, 32'h0000_0050, "cmp_read");
      wr(A_CMP, 32'h0000_AA00, 4'b0010);
      rd(A_CMP, 32'h0000_AA50, "cmp_lane_write");
      wr(A_TMR, 32'h1234_5600, 4'hF);
      wr(A_TMR, 32'h0000_00AB, 4'b0001);
      rd(A_TMR, 32'h1234_56AB, "timer_lane_write");
      wr(A_CMP, 32'h0000_0102, 4'hF);
      wr(A_TMR, 32'h0000_0100, 4'hF);
      idle(2);
      wr(A_CMP, 32'h0000_0102, 4'hF);
      chk(2, 32'h0, "cmp_clear_beats_match");
      idle(1);
      chk(2, 32'h0, "irq_stays_clear");
      wr(32'h300, 32'hCAFE_F00D, 4'hF);
      rd(32'h104, 32'hAA22_CC44, "pre_reset_read");
      wr(32'h304, 32'h1111_1111, 4'hF);
      rst_n = 1'b0;
      wr(32'h300, 32'h0BAD_BAD0, 4'hF);
      rst_n = 1'b1;
      chk(0, 32'h0, "midrst_dm"); chk(1, 32'h0, "midrst_led"); chk(2, 32'h0, "midrst_irq");
      idle(1);
      rd(A_TMR, 32'h0000_0001, "midrst_timer");
      rd(A_CMP, 32'hFFFF_FFFF, "midrst_cmp");
      rd(32'h300, 32'hCAFE_F00D, "ram_kept_no_write_in_reset");
      rd(32'h304, 32'h1111_1111, "ram_kept");
      for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
         n_fail += sb.size();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the MiniMIPS32 core: it answers the core's data port (`daddr`, `dce`, `we`, `din` → `dm`) with a synchronous, byte-lane-writable data RAM and a small MMIO page holding LED, switch, timer and compare registers. It sits outside the core, at the board/SoC top, opposite the core's MEM stage. Read data is registered so that it is valid exactly when the core's WB stage samples `dm`.

## Interface
- `RAM_AW`, 13: RAM word-address width; 2^RAM_AW words (default 32 KB).
- `MMIO_BASE_HI`, 16'hBFD0: value of `daddr[31:16]` that selects the MMIO page.
- `cpu_clk_50M` in 1: sole clock, rising edge.
- `cpu_rst_n` in 1: reset, synchronous, active-low.
- `daddr` in 32: byte address; `daddr[1:0]` ignored (word-aligned access).
- `dce` in 1: access enable for this cycle.
- `we` in 4: byte-lane write enables; `we[i]` writes `din[8i+7:8i]`; `4'b0000` means read.
- `din` in 32: store data, already lane-aligned by the core.
- `dm` out 32: registered read data.
- `sw` in 16: board switches, asynchronous.
- `led` out 16: LED register.
- `timer_irq` out 1: sticky compare-match flag.

## Operation
**Address decode**
- MMIO when `daddr[31:16] == MMIO_BASE_HI`; otherwise RAM.
- RAM word index is `daddr[RAM_AW+1:2]`; upper bits are aliased/ignored.

**Access types**
- Read: `dce=1`, `we=0`. On the next edge `dm` is loaded with the selected word.
- Write: `dce=1`, `we!=0`. Only the enabled lanes are written at the edge; `dm` holds its previous value.
- Idle: `dce=0`. No state change from the bus; `dm` holds.

**MMIO map** (offset = `daddr[15:0]`)
- 0x0 LED: RW, lanes 0–1 only; reads return zero-extended.
- 0x4 SW: RO, value of the 2-flop synchronized `sw`, zero-extended; writes ignored.
- 0x8 TIMER: RW 32-bit.
  - Increments every cycle, wraps 0xFFFFFFFF → 0.
  - A write replaces the count; written lanes take `din`, other lanes keep the pre-increment value.
  - Write wins over the increment in that cycle.
- 0xC COMPARE: RW 32-bit, per-lane write.
  - Any write to COMPARE clears `timer_irq`.
- Other offsets: read 0, writes ignored.

**Compare match**
- `timer_irq` sets when the current (pre-increment) TIMER equals COMPARE.
- If a COMPARE write coincides with a match, the clear wins.

## Timing
- Read latency is 1 cycle: `dm` is valid the cycle after the access, matching the MEM→WB register in the core.
- Back-to-back accesses are allowed every cycle; there is no stall or handshake.
- Store at cycle N followed by a load to the same address at N+1 returns the new data (write at edge N, read at edge N+1).
- Read and write in the same cycle cannot occur (single port, `we` selects).
- SW has 2 cycles of synchronizer latency plus 1 read cycle.
- Reset (`cpu_rst_n=0` at an edge):
  - `dm=0`, `led=0`, TIMER=0, COMPARE=0xFFFFFFFF, `timer_irq=0`, synchronizer flops=0.
  - RAM contents are not reset and are preserved.
  - Reset asserted mid-sequence overrides any access in that cycle; no write occurs.

## Structure
- Shared package `dmem_pkg`: MMIO offset constants (`MMIO_LED`, `MMIO_SW`, `MMIO_TIMER`, `MMIO_CMP`), `MMIO_BASE_HI` default, COMPARE reset value.
- Byte-lane write merge is a shared function in `dmem_pkg`, used by RAM, TIMER and COMPARE.
- Sub-module `dmem_ram`: single-port synchronous RAM, 4 byte-lane write enables, registered read, no reset, BRAM-inferable.
- Top level holds decode, MMIO registers, the timer and the read-data mux.
- The read mux selects RAM vs MMIO using a 1-cycle-delayed select, so `dm` is driven from the RAM's registered output.

## Test plan
- RAM word: write 0x12345678 @0x100 with `we=F`, read @0x100 → `dm=0x12345678` one cycle later; `dm` unchanged on the write cycle.
- Byte lanes: preload 0xAABBCCDD @0x104, write `din=0x11223344 we=4'b0101` → read 0xAA22CC44.
- Store then load: write 0xDEADBEEF @0x200 at N, read @0x200 at N+1 → `dm=0xDEADBEEF` at N+2.
- LED/SW: write 0x0000A5A5 to 0xBFD00000 → `led=0xA5A5`; set `sw=0x00F0`, wait 3 cycles, read 0xBFD00004 → 0x000000F0.
- Timer wrap/IRQ: write TIMER=0xFFFFFFFE, COMPARE=0x00000001 → TIMER wraps through 0; `timer_irq` rises when TIMER reaches 1; a COMPARE write clears it, including when it coincides with a match.
- Reset mid-run: assert `cpu_rst_n=0` during a write burst → all outputs reach their reset values after one edge; a RAM word written before reset reads back intact after reset.
